fmap_streamer: RTL and testbench
================================

Name: fmap_streamer

Overview:
- Drains a finished feature map from the convolution output RAM and emits it as a valid/ready pixel stream, in raster order.
- Sits downstream of the convolution block. It owns the RAM read port after `convolution` asserts `done`.
- Hides the 1-cycle synchronous RAM read latency behind a 2-entry prefetch buffer. Sustains 1 pixel/cycle when the sink never stalls.

Parameters:
- BIT_WIDTH, 16, pixel/RAM word width.
- RAM_DEPTH, 16, depth of the source RAM; address width is $clog2(RAM_DEPTH).
- OUT_X, 4, feature-map width in pixels.
- OUT_Y, 4, feature-map height in pixels. OUT_X*OUT_Y must be ≥1 and ≤ RAM_DEPTH-BASE_ADDR; the RTL enforces this with an elaboration-time check.
- BASE_ADDR, 0, RAM address of pixel (0,0).

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- start, input, 1, begin draining; sampled only in IDLE.
- addr_rd, output, $clog2(RAM_DEPTH), RAM read address.
- data_rd, input, BIT_WIDTH, RAM read data; valid the cycle after an address is issued.
- m_data, output, BIT_WIDTH, stream pixel.
- m_valid, output, 1, m_data valid.
- m_ready, input, 1, sink accepts the beat.
- m_last, output, 1, high with the final pixel (index N-1, N=OUT_X*OUT_Y).
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle pulse after the final beat is accepted.

Behaviour:
- **Reset (rst=0, async):**
  - State goes to IDLE; rd_idx, out_idx, FIFO occupancy and in-flight flag all clear.
  - addr_rd=BASE_ADDR, m_data=0, m_valid=0, m_last=0, busy=0, done=0.
  - Any in-flight read is discarded.
  - Reset mid-transfer aborts without a done pulse.
- **States:**
  - IDLE: start=1 → RUN.
  - RUN: final handshake → DONE.
  - DONE: one cycle with done=1 → IDLE.
  - start is ignored in RUN and DONE; no queuing.
- **Read issue (RUN only):**
  - addr_rd = BASE_ADDR + rd_idx, driven from a register.
  - rd_fire = (rd_idx < N) && (occ + inflight - pop) < 2, where pop = m_valid && m_ready.
  - On rd_fire, rd_idx increments and inflight is set for the next cycle.
  - addr_rd holds its last value when not firing. A read without rd_fire is harmless.
- **Capture:** when inflight=1, data_rd is written into the FIFO at the end of that cycle.
- **FIFO:** 2 entries. Simultaneous push and pop leaves occupancy unchanged.
  - Overflow is impossible by the credit rule; a bench assertion checks it.
  - Underflow is impossible because m_valid = (occ>0).
- **Output:**
  - m_data is the FIFO head.
  - m_last = m_valid && (out_idx == N-1).
  - out_idx increments on each handshake.
  - While m_valid && !m_ready, m_data and m_last stay stable and m_valid stays high.
- **Latency:**
  - start sampled at edge 0 → RUN and first rd_fire in cycle 1.
  - data_rd valid in cycle 2.
  - m_valid=1 in cycle 3.
  - With m_ready held 1, one beat per cycle in cycles 3..N+2.
  - done=1 in cycle N+3; IDLE and start-ready from cycle N+4.
- **Throughput under stall:** prefetch stops after 2 outstanding words; streaming resumes the cycle m_ready returns.
- **Width:** rd_idx and out_idx are $clog2(N+1) bits and never wrap; addresses never exceed BASE_ADDR+N-1.
- busy = (state==RUN).

Test Plan:
- Reset release, no start for 10 cycles → all outputs at reset values, addr_rd=BASE_ADDR.
- RAM preloaded with addr+0x100, OUT_X=OUT_Y=4, m_ready=1 → beats 0x100..0x10F in cycles 3..18, m_last only on 0x10F, done pulse cycle 19, busy cycles 1..18.
- Same preload, m_ready toggling 1,0,0,1 pattern → identical 16-value ordered sequence; m_data stable during stalls; no addresses beyond 15 issued.
- m_ready=0 for 20 cycles after start → exactly 2 reads issued (addr 0,1); m_valid held with m_data=0x100; release → remaining 14 beats in order.
- start re-pulsed in RUN and in the DONE cycle → ignored; start in the cycle after done → second full 16-beat stream.
- rst asserted after beat 5 accepted → outputs clear asynchronously, no done; next start streams from 0x100.

Source files
------------

// File: rtl/fmap_streamer.sv
// Drains a finished feature map from the convolution output RAM as a valid/ready
// raster-order pixel stream, hiding the 1-cycle RAM read latency with a 2-entry prefetch FIFO.
module fmap_streamer #(
   parameter int BIT_WIDTH = 16,
   parameter int RAM_DEPTH = 16,
   parameter int OUT_X     = 4,
   parameter int OUT_Y     = 4,
   parameter int BASE_ADDR = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   output logic [$clog2(RAM_DEPTH)-1:0] addr_rd,
   input  logic [BIT_WIDTH-1:0]         data_rd,
   output logic [BIT_WIDTH-1:0]         m_data,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic                         m_last,
   output logic                         busy,
   output logic                         done
);

   localparam int N  = OUT_X * OUT_Y;
   localparam int AW = $clog2(RAM_DEPTH);
   localparam int CW = $clog2(N + 1);

   if (N < 1 || N > RAM_DEPTH - BASE_ADDR) begin : g_bad_geometry
      $error("fmap_streamer: OUT_X*OUT_Y must lie in 1..RAM_DEPTH-BASE_ADDR");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        rd_idx_q, rd_idx_d;
   logic [CW-1:0]        out_idx_q, out_idx_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic                 inflight_q, inflight_d;
   logic [1:0]           occ_q, occ_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic [BIT_WIDTH-1:0] mem_q [2];
   logic [BIT_WIDTH-1:0] mem_d [2];
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 pop;
   logic                 push;
   logic                 rd_fire;
   logic [2:0]           pend;

   always_comb begin
      pop     = (occ_q != 2'd0) && m_ready;
      push    = inflight_q;
      // Credit counts words held plus the one landing this cycle, minus the one leaving.
      pend    = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
      rd_fire = (state_q == RUN) && (rd_idx_q < CW'(N)) && (pend < 3'd2);

      state_d    = state_q;
      rd_idx_d   = rd_idx_q;
      out_idx_d  = out_idx_q;
      addr_d     = addr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mem_d      = mem_q;
      busy_d     = busy_q;
      done_d     = done_q;
      inflight_d = rd_fire;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               rd_idx_d  = '0;
               out_idx_d = '0;
               addr_d    = AW'(BASE_ADDR);
               busy_d    = 1'b1;
            end
         end
         RUN: begin
            if (pop && out_idx_q == CW'(N - 1)) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase

      // addr_q always presents the next word to fetch, so the RAM sees it in the firing cycle.
      if (rd_fire) begin
         rd_idx_d = rd_idx_q + 1'b1;
         if (rd_idx_q < CW'(N - 1)) addr_d = addr_q + 1'b1;
      end

      if (push) begin
         mem_d[wr_ptr_q] = data_rd;
         wr_ptr_d        = ~wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d  = ~rd_ptr_q;
         out_idx_d = out_idx_q + 1'b1;
      end

      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rd_idx_q   <= '0;
         out_idx_q  <= '0;
         addr_q     <= AW'(BASE_ADDR);
         inflight_q <= 1'b0;
         occ_q      <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_idx_q   <= rd_idx_d;
         out_idx_q  <= out_idx_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_q      <= mem_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign addr_rd = addr_q;
   assign m_data  = mem_q[rd_ptr_q];
   assign m_valid = (occ_q != 2'd0);
   assign m_last  = m_valid && (out_idx_q == CW'(N - 1));
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_fmap_streamer.sv
// Directed bench for fmap_streamer: 4x4 map, synchronous RAM model holding addr+0x100.
module tb_fmap_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  addr_rd;
   logic [15:0] data_rd;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
   logic        done;

   int checks = 0;
   int passes = 0;

   fmap_streamer #(
      .BIT_WIDTH(16),
      .RAM_DEPTH(16),
      .OUT_X(4),
      .OUT_Y(4),
      .BASE_ADDR(0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .addr_rd(addr_rd),
      .data_rd(data_rd),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_last(m_last),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // RAM model: one-cycle synchronous read, word = address + 0x100
   always @(posedge clk) data_rd <= 16'h0100 + {12'h000, addr_rd};

   always @(negedge clk)
      if (rst === 1'b1)
         assert (dut.occ_q != 2'd3) else $error("FAIL fifo_overflow occ=%0d required<=2", dut.occ_q);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; m_ready = 1'b0;
      tick(); tick();
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_held valid=%b busy=%b done=%b required 0/0/0", m_valid, busy, done);
      else passes++;
      rst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      checks++; if (addr_rd !== 4'd0) $display("FAIL reset_addr got=%0d required=0", addr_rd); else passes++;
      checks++; if (m_data !== 16'h0000) $display("FAIL reset_data got=%h required=0000", m_data); else passes++;
      checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid got=%b required=0", m_valid); else passes++;
      checks++; if (m_last !== 1'b0) $display("FAIL reset_last got=%b required=0", m_last); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b required=0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b required=0", done); else passes++;
   endtask

   task automatic test_stream();
      logic [15:0] exp_d;
      m_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         checks++;
         if (busy !== (cyc <= 18)) $display("FAIL stream_busy cyc=%0d got=%b required=%b", cyc, busy, cyc <= 18);
         else passes++;
         checks++;
         if (done !== (cyc == 19)) $display("FAIL stream_done cyc=%0d got=%b required=%b", cyc, done, cyc == 19);
         else passes++;
         checks++;
         if (m_valid !== (cyc >= 3 && cyc <= 18))
            $display("FAIL stream_valid cyc=%0d got=%b required=%b", cyc, m_valid, cyc >= 3 && cyc <= 18);
         else passes++;
         if (cyc >= 3 && cyc <= 18) begin
            exp_d = 16'(16'h0100 + cyc - 3);
            checks++;
            if (m_data !== exp_d) $display("FAIL stream_data cyc=%0d got=%h required=%h", cyc, m_data, exp_d);
            else passes++;
            checks++;
            if (m_last !== (cyc == 18)) $display("FAIL stream_last cyc=%0d got=%b required=%b", cyc, m_last, cyc == 18);
            else passes++;
         end
         tick();
      end
   endtask

   task automatic test_ready_toggle();
      logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int          beat = 0;
      logic        stalled = 1'b0;
      logic        seen_done = 1'b0;
      logic [15:0] prev_d = '0;
      logic        prev_l = 1'b0;
      logic [3:0]  prev_a = '0;
      start = 1'b1; tick(); start = 1'b0;
      for (int cyc = 1; cyc <= 100 && !seen_done; cyc++) begin
         m_ready = pat[cyc % 4];
         if (stalled) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_d || m_last !== prev_l)
               $display("FAIL toggle_hold cyc=%0d got v=%b d=%h l=%b required v=1 d=%h l=%b",
                        cyc, m_valid, m_data, m_last, prev_d, prev_l);
            else passes++;
         end
         checks++;
         if (addr_rd < prev_a) $display("FAIL toggle_addr_wrap cyc=%0d got=%0d required>=%0d", cyc, addr_rd, prev_a);
         else passes++;
         prev_a = addr_rd;
         if (m_valid && m_ready) begin
            checks++;
            if (m_data !== 16'(16'h0100 + beat))
               $display("FAIL toggle_data beat=%0d got=%h required=%h", beat, m_data, 16'(16'h0100 + beat));
            else passes++;
            checks++;
            if (m_last !== (beat == 15)) $display("FAIL toggle_last beat=%0d got=%b required=%b", beat, m_last, beat == 15);
            else passes++;
            beat++;
         end
         stalled = m_valid && !m_ready;
         prev_d  = m_data;
         prev_l  = m_last;
         if (done) seen_done = 1'b1;
         tick();
      end
      checks++; if (beat != 16) $display("FAIL toggle_count got=%0d required=16", beat); else passes++;
      checks++; if (!seen_done) $display("FAIL toggle_done_timeout got=0 required=1"); else passes++;
      m_ready = 1'b1;
      tick();
   endtask

   task automatic test_stall();
      logic [3:0] exp_a;
      m_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         exp_a = (cyc == 1) ? 4'd0 : (cyc == 2) ? 4'd1 : 4'd2;
         checks++;
         if (addr_rd !== exp_a) $display("FAIL stall_addr cyc=%0d got=%0d required=%0d", cyc, addr_rd, exp_a);
         else passes++;
         if (cyc >= 3) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'h0100 || m_last !== 1'b0)
               $display("FAIL stall_hold cyc=%0d got v=%b d=%h l=%b required v=1 d=0100 l=0",
                        cyc, m_valid, m_data, m_last);
            else passes++;
         end
         tick();
      end
      m_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== 16'(16'h0100 + k) || m_last !== (k == 15))
            $display("FAIL stall_release k=%0d got v=%b d=%h l=%b required v=1 d=%h l=%b",
                     k, m_valid, m_data, m_last, 16'(16'h0100 + k), k == 15);
         else passes++;
         tick();
      end
      checks++; if (done !== 1'b1) $display("FAIL stall_done got=%b required=1", done); else passes++;
      tick();
   endtask

   task automatic test_start_ignored();
      m_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         start = (cyc == 5 || cyc == 19 || cyc == 20);
         if (cyc == 19) begin
            checks++; if (done !== 1'b1) $display("FAIL restart_done1 got=%b required=1", done); else passes++;
         end
         if (cyc == 20) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0)
               $display("FAIL restart_done_ignored got busy=%b done=%b required 0/0", busy, done);
            else passes++;
         end
         if (cyc >= 3 && cyc <= 18) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'(16'h0100 + cyc - 3))
               $display("FAIL restart_run1 cyc=%0d got v=%b d=%h required v=1 d=%h",
                        cyc, m_valid, m_data, 16'(16'h0100 + cyc - 3));
            else passes++;
         end
         tick();
      end
      start = 1'b0;
      for (int cyc = 1; cyc <= 19; cyc++) begin
         if (cyc >= 3 && cyc <= 18) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'(16'h0100 + cyc - 3) || m_last !== (cyc == 18))
               $display("FAIL restart_run2 cyc=%0d got v=%b d=%h l=%b required v=1 d=%h l=%b",
                        cyc, m_valid, m_data, m_last, 16'(16'h0100 + cyc - 3), cyc == 18);
            else passes++;
         end
         if (cyc == 19) begin
            checks++; if (done !== 1'b1) $display("FAIL restart_done2 got=%b required=1", done); else passes++;
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      m_ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int cyc = 1; cyc <= 8; cyc++) tick();
      rst = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0 || m_data !== 16'h0000 || addr_rd !== 4'd0)
         $display("FAIL midreset_clear got v=%b b=%b l=%b d=%h a=%0d required 0/0/0/0000/0",
                  m_valid, busy, m_last, m_data, addr_rd);
      else passes++;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (done !== 1'b0) $display("FAIL midreset_no_done i=%0d got=%b required=0", i, done); else passes++;
      end
      rst = 1'b1;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      for (int cyc = 1; cyc <= 19; cyc++) begin
         if (cyc >= 3 && cyc <= 18) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'(16'h0100 + cyc - 3))
               $display("FAIL midreset_restream cyc=%0d got v=%b d=%h required v=1 d=%h",
                        cyc, m_valid, m_data, 16'(16'h0100 + cyc - 3));
            else passes++;
         end
         if (cyc == 19) begin
            checks++; if (done !== 1'b1) $display("FAIL midreset_done got=%b required=1", done); else passes++;
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_ready_toggle();
      test_stall();
      test_start_ignored();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
